controle_busca: RTL and testbench

Fetch controller for the Redux-V core: owns the 8-bit program counter, drives the address of `memoria_instrucoes`, latches the returned instruction, and hands it to the decode stage over a valid/ready handshake. It applies branch redirects, detects the halt opcode and the end of instruction memory, and counts retired instructions. It sits between `memoria_instrucoes` and the decoder and replaces free-running PC stepping.

---
 rtl/redux_pkg.sv | 17 +
 rtl/contador_de_programa.sv | 43 ++++
 rtl/controle_busca.sv | 111 +++++++++++
 tb/tb_controle_busca.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/redux_pkg.sv
// Shared definitions for the Redux-V core: datapath widths, the halt opcode
// and the fetch controller state encoding.
package redux_pkg;

  localparam int LARGURA_PC    = 8;
  localparam int LARGURA_INSTR = 8;

  localparam logic [LARGURA_INSTR-1:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    BUSCA   = 2'b01,
    ENTREGA = 2'b10,
    PARADO  = 2'b11
  } estado_t;

endpackage : redux_pkg

// File: rtl/contador_de_programa.sv
// Program counter register: restart load, branch load and increment.
// Holds its value whenever no command is asserted.
module contador_de_programa
  import redux_pkg::*;
#(
  parameter logic [LARGURA_PC-1:0] PC_INICIAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  carregar_inicial_i,
  input  logic                  carregar_alvo_i,
  input  logic                  incrementar_i,
  input  logic [LARGURA_PC-1:0] alvo_i,
  output logic [LARGURA_PC-1:0] pc_o
);

  logic [LARGURA_PC-1:0] pc_q, pc_d;

  // NOTE: every path assigns pc_d from the default first, so no latch forms.
  always_comb begin
    pc_d = pc_q;
    if (carregar_inicial_i) begin
      pc_d = PC_INICIAL;
    end else if (carregar_alvo_i) begin
      pc_d = alvo_i;
    end else if (incrementar_i) begin
      pc_d = pc_q + LARGURA_PC'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_INICIAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : contador_de_programa

// File: rtl/controle_busca.sv
// Fetch controller: drives the instruction memory address, latches the
// instruction, delivers it over valid/ready and counts retired instructions.
module controle_busca
  import redux_pkg::*;
#(
  parameter logic [LARGURA_PC-1:0] PC_INICIAL = 8'h00,
  parameter logic [LARGURA_PC-1:0] LIMITE     = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iniciar,
  output logic [LARGURA_PC-1:0]    endereco,
  input  logic [LARGURA_INSTR-1:0] instrucao,
  output logic [LARGURA_INSTR-1:0] instr_saida,
  output logic                     instr_valida,
  input  logic                     instr_pronta,
  input  logic                     desvio,
  input  logic [LARGURA_PC-1:0]    alvo,
  output logic                     ocupado,
  output logic                     parado,
  output logic [15:0]              contagem
);

  estado_t                  estado_q, estado_d;
  logic [LARGURA_INSTR-1:0] ir_q, ir_d;
  logic [15:0]              contagem_q, contagem_d;
  logic                     carregar_inicial, carregar_alvo, incrementar;
  logic [LARGURA_PC-1:0]    pc;

  contador_de_programa #(
    .PC_INICIAL(PC_INICIAL)
  ) u_pc (
    .clk               (clk),
    .rst               (rst),
    .carregar_inicial_i(carregar_inicial),
    .carregar_alvo_i   (carregar_alvo),
    .incrementar_i     (incrementar),
    .alvo_i            (alvo),
    .pc_o              (pc)
  );

  always_comb begin
    estado_d         = estado_q;
    ir_d             = ir_q;
    contagem_d       = contagem_q;
    carregar_inicial = 1'b0;
    carregar_alvo    = 1'b0;
    incrementar      = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          carregar_inicial = 1'b1;
          estado_d         = BUSCA;
        end
      end
      BUSCA: begin
        if (instrucao == OP_HALT) begin
          estado_d = PARADO;
        end else begin
          ir_d     = instrucao;
          estado_d = ENTREGA;
        end
      end
      ENTREGA: begin
        if (instr_pronta) begin
          contagem_d = (contagem_q == 16'hFFFF) ? contagem_q : contagem_q + 16'd1;
          // A taken branch wins over the end-of-memory check.
          if (desvio) begin
            carregar_alvo = 1'b1;
            estado_d      = BUSCA;
          end else if (pc == LIMITE) begin
            estado_d = PARADO;
          end else begin
            incrementar = 1'b1;
            estado_d    = BUSCA;
          end
        end
      end
      PARADO: begin
        if (iniciar) begin
          carregar_inicial = 1'b1;
          contagem_d       = 16'd0;
          estado_d         = BUSCA;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      ir_q       <= '0;
      contagem_q <= '0;
    end else begin
      estado_q   <= estado_d;
      ir_q       <= ir_d;
      contagem_q <= contagem_d;
    end
  end

  // Outputs come from registers or state decode only; nothing depends on instr_pronta.
  assign endereco     = pc;
  assign instr_saida  = ir_q;
  assign instr_valida = (estado_q == ENTREGA);
  assign ocupado      = (estado_q == BUSCA) || (estado_q == ENTREGA);
  assign parado       = (estado_q == PARADO);
  assign contagem     = contagem_q;

endmodule : controle_busca

// File: tb/tb_controle_busca.sv
// Directed bench for controle_busca: start, backpressure, branch, halt opcode,
// end-of-memory limit with restart, and asynchronous reset during delivery.
module tb_controle_busca;

  logic        clk = 1'b0;
  logic        rst;
  logic        iniciar, pronta, desvio;
  logic [7:0]  alvo;
  logic [7:0]  endereco, instrucao, instr_saida;
  logic        instr_valida, ocupado, parado;
  logic [15:0] contagem;

  logic        iniciar2, pronta2, desvio2;
  logic [7:0]  alvo2;
  logic [7:0]  endereco2, instrucao2, saida2;
  logic        valida2, ocupado2, parado2;
  logic [15:0] contagem2;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign instrucao  = mem[endereco];
  assign instrucao2 = mem[endereco2];

  controle_busca #(.PC_INICIAL(8'h00), .LIMITE(8'hFF)) u_dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .endereco(endereco),
    .instrucao(instrucao), .instr_saida(instr_saida), .instr_valida(instr_valida),
    .instr_pronta(pronta), .desvio(desvio), .alvo(alvo), .ocupado(ocupado),
    .parado(parado), .contagem(contagem)
  );

  controle_busca #(.PC_INICIAL(8'h00), .LIMITE(8'h04)) u_dut_lim (
    .clk(clk), .rst(rst), .iniciar(iniciar2), .endereco(endereco2),
    .instrucao(instrucao2), .instr_saida(saida2), .instr_valida(valida2),
    .instr_pronta(pronta2), .desvio(desvio2), .alvo(alvo2), .ocupado(ocupado2),
    .parado(parado2), .contagem(contagem2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iniciar = 1'b0; pronta = 1'b1; desvio = 1'b0; alvo = 8'h00;
    iniciar2 = 1'b0; pronta2 = 1'b1; desvio2 = 1'b0; alvo2 = 8'h00;
    // mem[i] = i + 0x10, with the halt opcode planted at address 7
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    mem[7] = 8'hFF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("rst_endereco", 16'(endereco), 16'h00);
    check("rst_saida", 16'(instr_saida), 16'h00);
    check("rst_valida", 16'(instr_valida), 16'h0);
    check("rst_ocupado", 16'(ocupado), 16'h0);
    check("rst_parado", 16'(parado), 16'h0);
    check("rst_contagem", contagem, 16'h0);

    // start: BUSCA after edge N, valid after edge N+1
    iniciar = 1'b1; step(); iniciar = 1'b0;
    check("ini_ocupado", 16'(ocupado), 16'h1);
    check("ini_valida", 16'(instr_valida), 16'h0);
    step();
    check("e0_valida", 16'(instr_valida), 16'h1);
    check("e0_saida", 16'(instr_saida), 16'h10);
    check("e0_endereco", 16'(endereco), 16'h00);
    step();
    check("h0_valida", 16'(instr_valida), 16'h0);
    check("h0_endereco", 16'(endereco), 16'h01);
    check("h0_contagem", contagem, 16'd1);
    step();
    check("e1_saida", 16'(instr_saida), 16'h11);
    step();
    check("h1_endereco", 16'(endereco), 16'h02);
    check("h1_contagem", contagem, 16'd2);
    step();
    step();
    check("h2_endereco", 16'(endereco), 16'h03);
    check("h2_contagem", contagem, 16'd3);

    // backpressure at PC=3; iniciar is ignored while busy
    pronta = 1'b0; iniciar = 1'b1;
    step(); iniciar = 1'b0;
    check("e3_saida", 16'(instr_saida), 16'h13);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_endereco", 16'(endereco), 16'h03);
      check("bp_saida", 16'(instr_saida), 16'h13);
      check("bp_contagem", contagem, 16'd3);
      check("bp_valida", 16'(instr_valida), 16'h1);
    end
    pronta = 1'b1; step();
    check("h3_endereco", 16'(endereco), 16'h04);
    check("h3_contagem", contagem, 16'd4);
    step(); step();
    check("h4_endereco", 16'(endereco), 16'h05);

    // desvio during BUSCA (no valid instruction) must be ignored
    desvio = 1'b1; alvo = 8'h20;
    step();
    check("desvio_ignorado", 16'(endereco), 16'h05);
    check("e5_saida", 16'(instr_saida), 16'h15);
    alvo = 8'h40;
    step();
    desvio = 1'b0;
    check("br_endereco", 16'(endereco), 16'h40);
    check("br_contagem", contagem, 16'd6);
    step();
    check("e40_saida", 16'(instr_saida), 16'h50);
    desvio = 1'b1; alvo = 8'h06;
    step();
    desvio = 1'b0;
    check("br6_endereco", 16'(endereco), 16'h06);
    check("br6_contagem", contagem, 16'd7);
    step();
    check("e6_saida", 16'(instr_saida), 16'h16);
    step();
    check("h6_endereco", 16'(endereco), 16'h07);
    step();
    check("halt_parado", 16'(parado), 16'h1);
    check("halt_endereco", 16'(endereco), 16'h07);
    check("halt_contagem", contagem, 16'd8);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_valida", 16'(instr_valida), 16'h0);
      check("halt_pc_fixo", 16'(endereco), 16'h07);
    end

    // restart from PARADO, straight run 0..6 halts at 7 with 7 retired
    iniciar = 1'b1; step(); iniciar = 1'b0;
    check("rs_contagem", contagem, 16'd0);
    check("rs_endereco", 16'(endereco), 16'h00);
    check("rs_ocupado", 16'(ocupado), 16'h1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("run_saida", 16'(instr_saida), 16'(i + 16));
      step();
      check("run_contagem", contagem, 16'(i + 1));
    end
    step();
    check("run_parado", 16'(parado), 16'h1);
    check("run_endereco", 16'(endereco), 16'h07);
    check("run_contagem7", contagem, 16'd7);
    check("run_valida", 16'(instr_valida), 16'h0);

    // LIMITE=4 instance: halts after the handshake at address 4
    iniciar2 = 1'b1; step(); iniciar2 = 1'b0;
    for (int n = 0; n < 40 && !parado2; n++) step();
    check("lim_parado", 16'(parado2), 16'h1);
    check("lim_contagem", contagem2, 16'd5);
    check("lim_endereco", 16'(endereco2), 16'h04);
    iniciar2 = 1'b1; step(); iniciar2 = 1'b0;
    check("lim_rs_contagem", contagem2, 16'd0);
    check("lim_rs_endereco", 16'(endereco2), 16'h00);
    check("lim_rs_ocupado", 16'(ocupado2), 16'h1);
    step();
    check("lim_rs_valida", 16'(valida2), 16'h1);
    check("lim_rs_saida", 16'(saida2), 16'h10);

    // asynchronous reset between edges while an instruction is pending
    iniciar = 1'b1; step(); iniciar = 1'b0;
    pronta = 1'b0;
    step();
    check("ar_pre_valida", 16'(instr_valida), 16'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_valida", 16'(instr_valida), 16'h0);
    check("ar_saida", 16'(instr_saida), 16'h00);
    check("ar_endereco", 16'(endereco), 16'h00);
    check("ar_ocupado", 16'(ocupado), 16'h0);
    check("ar_parado", 16'(parado), 16'h0);
    check("ar_contagem", contagem, 16'h0);
    check("ar_lim_ocupado", 16'(ocupado2), 16'h0);
    step();
    rst = 1'b0;
    step();
    check("ar_post_valida", 16'(instr_valida), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_controle_busca
